// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential 8x8 nibble multiplier.
//   - state_t         : controller states
//   - OP_W/NIB_W/...  : operand, nibble, product, step and shift widths
//   - SHIFT_STEPn     : partial-product shift for each nibble step
//   - csa_reduce_4x4  : 4x4 partial-product carry-save reduction shared by both 4x4 cores
package mult_seq_pkg;

    localparam int OP_W    = 8;
    localparam int NIB_W   = 4;
    localparam int PROD_W  = 16;
    localparam int STEP_W  = 2;
    localparam int SHIFT_W = 4;

    localparam logic [STEP_W-1:0]  STEP_LAST   = 2'd3;
    localparam logic [SHIFT_W-1:0] SHIFT_STEP0 = 4'd0;
    localparam logic [SHIFT_W-1:0] SHIFT_STEP1 = 4'd4;
    localparam logic [SHIFT_W-1:0] SHIFT_STEP2 = 4'd4;
    localparam logic [SHIFT_W-1:0] SHIFT_STEP3 = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reduces the four AND-array rows to a sum/carry pair with two 3:2 layers.
    // The true product is below 256, so dropping carries out of bit 7 is exact.
    // Returns {sum, carry}.
    function automatic logic [15:0] csa_reduce_4x4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] r0, r1, r2, r3, s1, c1, s2, c2;
        r0 = {4'b0000, x & {4{y[0]}}};
        r1 = {3'b000,  x & {4{y[1]}}, 1'b0};
        r2 = {2'b00,   x & {4{y[2]}}, 2'b00};
        r3 = {1'b0,    x & {4{y[3]}}, 3'b000};
        s1 = r0 ^ r1 ^ r2;
        c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
        s2 = s1 ^ c1 ^ r3;
        c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;
        return {s2, c2};
    endfunction

endpackage

// File: rtl/mult4_cores.sv
// Combinational 4x4 -> 8 unsigned multiplier cores.
//   multiplier_4bits_version7     : carry-save reduction + Kogge-Stone final adder
//   multiplier_4bits_version7_CLA : carry-save reduction + carry-lookahead final adder
// Ports (both): a[3:0], b[3:0] operands; p[7:0] product.
module multiplier_4bits_version7
    import mult_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    function automatic logic [7:0] ks_add8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] g, pg, hs;
        g  = x & y;
        pg = x ^ y;
        hs = pg;
        // Prefix levels at distance 1, 2, 4; descending index keeps the
        // lower bits at their previous-level values within a level.
        for (int d = 1; d < 8; d = d * 2) begin
            for (int i = 7; i >= d; i--) begin
                g[i]  = g[i] | (pg[i] & g[i-d]);
                pg[i] = pg[i] & pg[i-d];
            end
        end
        return hs ^ {g[6:0], 1'b0};
    endfunction

    logic [7:0] s_row, c_row;

    assign {s_row, c_row} = csa_reduce_4x4(a, b);
    assign p = ks_add8(s_row, c_row);

endmodule

module multiplier_4bits_version7_CLA
    import mult_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    // Every carry is expanded directly from generate/propagate terms,
    // so no carry depends on another carry.
    function automatic logic [7:0] cla_add8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] g, pg, cy;
        logic       term;
        g  = x & y;
        pg = x ^ y;
        cy = '0;
        for (int i = 0; i < 7; i++) begin
            cy[i+1] = g[i];
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & pg[k];
                end
                cy[i+1] = cy[i+1] | term;
            end
        end
        return pg ^ cy;
    endfunction

    logic [7:0] s_row, c_row;

    assign {s_row, c_row} = csa_reduce_4x4(a, b);
    assign p = cla_add8(s_row, c_row);

endmodule

// File: rtl/mult8_nibble_sel.sv
// Nibble-pair selector for the sequential multiplier.
// Ports: a_q, b_q latched operands; step current nibble step;
//        nib_a, nib_b core operands; shift left shift of the partial product.
module mult8_nibble_sel
    import mult_seq_pkg::*;
(
    input  logic [OP_W-1:0]    a_q,
    input  logic [OP_W-1:0]    b_q,
    input  logic [STEP_W-1:0]  step,
    output logic [NIB_W-1:0]   nib_a,
    output logic [NIB_W-1:0]   nib_b,
    output logic [SHIFT_W-1:0] shift
);

    always_comb begin
        nib_a = a_q[NIB_W-1:0];
        nib_b = b_q[NIB_W-1:0];
        shift = SHIFT_STEP0;
        case (step)
            2'd1: begin
                nib_b = b_q[OP_W-1:NIB_W];
                shift = SHIFT_STEP1;
            end
            2'd2: begin
                nib_a = a_q[OP_W-1:NIB_W];
                shift = SHIFT_STEP2;
            end
            2'd3: begin
                nib_a = a_q[OP_W-1:NIB_W];
                nib_b = b_q[OP_W-1:NIB_W];
                shift = SHIFT_STEP3;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential unsigned 8x8 -> 16 multiplier: one combinational 4x4 core is
// reused over four nibble steps and the shifted partial products accumulate.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b)
//   out_valid/out_ready product handshake (product)
//   busy                high while multiplying or holding a result
// Parameters: MUL_VARIANT selects the 4x4 core (0 Kogge-Stone, 1 CLA);
//             ZERO_SKIP=1 sends a zero operand straight to DONE.
module mult8_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int MUL_VARIANT = 0,
    parameter int ZERO_SKIP   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    localparam bit SKIP_EN = (ZERO_SKIP != 0);

    state_t              state, state_nxt;
    logic [STEP_W-1:0]   step;
    logic [PROD_W-1:0]   acc;
    logic [OP_W-1:0]     a_q, b_q;
    logic [NIB_W-1:0]    nib_a, nib_b;
    logic [SHIFT_W-1:0]  shift;
    logic [2*NIB_W-1:0]  pp8;
    logic [PROD_W-1:0]   pp_shifted;
    logic                accept;
    logic                zero_op;

    assign accept  = in_valid && (state == IDLE);
    assign zero_op = (a == '0) || (b == '0);

    mult8_nibble_sel u_sel (
        .a_q   (a_q),
        .b_q   (b_q),
        .step  (step),
        .nib_a (nib_a),
        .nib_b (nib_b),
        .shift (shift)
    );

    generate
        if (MUL_VARIANT == 0) begin : g_core_ks
            multiplier_4bits_version7 u_core (
                .a (nib_a),
                .b (nib_b),
                .p (pp8)
            );
        end else begin : g_core_cla
            multiplier_4bits_version7_CLA u_core (
                .a (nib_a),
                .b (nib_b),
                .p (pp8)
            );
        end
    endgenerate

    assign pp_shifted = {{(PROD_W-2*NIB_W){1'b0}}, pp8} << shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode the registered state only, so an asynchronous reset
    // drops out_valid and product at once.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        product   = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = (SKIP_EN && zero_op) ? DONE : MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (step == STEP_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                product   = acc;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sum never exceeds 0xFE01, so the 16-bit accumulate cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            acc  <= '0;
            step <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q  <= a;
                        b_q  <= b;
                        acc  <= '0;
                        step <= '0;
                    end
                end
                MUL: begin
                    acc  <= acc + pp_shifted;
                    step <= (step == STEP_LAST) ? '0 : step + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
